// File: rtl/pc_trace_uart.sv
// pc_trace_uart
//   Watches the CPU program counter, captures every new value into a small
//   FIFO and streams captured values out over a UART 8N1 line as 4-byte
//   big-endian words.
//
// Parameters
//   CLK_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_AW      FIFO address width, depth = 2**FIFO_AW words of 32 bits
//
// Ports
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset
//   pc_       in   [31:0] program counter, sampled every cycle
//   txd       out  UART serial line, idle high, registered
//   busy      out  FIFO non-empty or a frame in flight
//   overflow  out  sticky: a capture was dropped on a full FIFO
//
// FSM states
//   state | meaning
//   IDLE  | line high, waiting for a FIFO entry to pop
//   START | start bit (0) of the current byte
//   DATA  | 8 data bits of the current byte, LSB first
//   STOP  | stop bit (1); then next byte of the word, or back to IDLE
module pc_trace_uart #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_,
  output logic        txd,
  output logic        busy,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_TC = BW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [31:0]       last_pc;
  logic [31:0]       mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr;
  logic [FIFO_AW:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              push_req;
  logic              push;
  logic              pop;
  logic [31:0]       shreg;
  logic [1:0]        byte_idx;
  logic [2:0]        bit_idx;
  logic [BW-1:0]     baud;
  logic              baud_tc;
  logic [7:0]        cur_byte;

  // Full/empty come from registered pointers only, so a pop in the same
  // cycle never frees a slot for that cycle's push.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                    (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
  assign push_req = (pc_ != last_pc);
  assign push     = push_req && !full;
  assign pop      = (state == IDLE) && !empty;
  assign baud_tc  = (baud == BAUD_TC);
  assign busy     = (state != IDLE) || !empty;

  // Word goes out most significant byte first.
  always_comb begin
    cur_byte = shreg[31:24];
    case (byte_idx)
      2'd0: cur_byte = shreg[31:24];
      2'd1: cur_byte = shreg[23:16];
      2'd2: cur_byte = shreg[15:8];
      2'd3: cur_byte = shreg[7:0];
      default: cur_byte = shreg[31:24];
    endcase
  end

  // Capture side. last_pc follows pc_ even when the push is dropped, so a
  // dropped value is not retried on the next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_pc  <= 32'hFFFF_FFFF;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_req) begin
        last_pc <= pc_;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push_req && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= pc_;
    end
  end

  // Transmit FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      txd      <= 1'b1;
      rd_ptr   <= '0;
      shreg    <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud     <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd  <= 1'b1;
          baud <= '0;
          if (pop) begin
            shreg    <= mem[rd_ptr[FIFO_AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
            byte_idx <= '0;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            baud    <= '0;
            bit_idx <= '0;
            txd     <= cur_byte[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud <= '0;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          baud  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_trace_uart.sv
// Testbench for pc_trace_uart: directed PC sequences, expected words queued
// at stimulus time and checked by an independent UART frame monitor.
module tb_pc_trace_uart;

  localparam int CPB    = 4;
  localparam int AW     = 4;
  localparam int FRAME  = 40 * CPB;
  localparam int PERIOD = FRAME + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc_ = 32'hFFFF_FFFF;
  logic        txd;
  logic        busy;
  logic        overflow;

  int n_cmp  = 0;
  int n_mis  = 0;
  int frames = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];
  int          starts[$];

  pc_trace_uart #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rstn(rstn), .pc_(pc_),
    .txd(txd), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame monitor: decodes 4 bytes back to back, checking every sample of
  // every bit slot; abandons a frame cut by reset.
  initial begin : monitor
    logic [159:0] smp;
    logic         ok;
    logic         ferr;
    logic [31:0]  w;
    logic [7:0]   by;
    int           st;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        st  = cyc;
        smp = '0;
        ok  = 1'b1;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (rstn !== 1'b1) begin
            ok = 1'b0;
            break;
          end
          smp[i] = txd;
        end
        if (ok) begin
          ferr = 1'b0;
          w    = '0;
          for (int b = 0; b < 4; b++) begin
            by = '0;
            for (int j = 0; j < 10; j++) begin
              for (int s = 1; s < CPB; s++)
                if (smp[b*10*CPB + j*CPB + s] !== smp[b*10*CPB + j*CPB]) ferr = 1'b1;
              if (j == 0 && smp[b*10*CPB] !== 1'b0) ferr = 1'b1;
              if (j == 9 && smp[b*10*CPB + 9*CPB] !== 1'b1) ferr = 1'b1;
              if (j >= 1 && j <= 8) by[j-1] = smp[b*10*CPB + j*CPB];
            end
            w = {w[23:0], by};
          end
          frames++;
          starts.push_back(st);
          chk("framing", {31'd0, ferr}, 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_frame: got %h expected no frame", w);
          end else begin
            chk("word", w, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset(input logic [31:0] pc_hold);
    @(negedge clk);
    pc_  = pc_hold;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    rstn = 1'b1;
  endtask

  // Called right after the negedge preceding capture edge E0.
  task automatic check_lat();
    @(negedge clk);
    chk("lat_e0_txd", {31'd0, txd}, 32'd1);
    chk("lat_e0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("lat_e1_txd", {31'd0, txd}, 32'd0);
  endtask

  task automatic drive_pc(input logic [31:0] v);
    @(negedge clk);
    pc_ = v;
    exp_q.push_back(v);
    check_lat();
  endtask

  initial begin : stim
    int f0;
    logic [31:0] v;

    // 1: single word 0x00000004
    do_reset(32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    f0 = frames;
    drive_pc(32'h0000_0004);
    repeat (FRAME + 10) @(negedge clk);
    chk("t1_frames", frames - f0, 32'd1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_queue", exp_q.size(), 32'd0);

    // 2: 0 from reset, then 4, 8, 12 spaced 200 cycles
    do_reset(32'h0000_0000);
    f0 = frames;
    exp_q.push_back(32'h0000_0000);
    check_lat();
    for (int k = 1; k <= 3; k++) begin
      repeat (197) @(negedge clk);
      drive_pc(32'(k * 4));
    end
    repeat (FRAME + 10) @(negedge clk);
    chk("t2_frames", frames - f0, 32'd4);
    chk("t2_overflow", {31'd0, overflow}, 32'd0);
    chk("t2_queue", exp_q.size(), 32'd0);

    // 3: constant 5 for 1000 cycles -> one frame
    do_reset(32'hFFFF_FFFF);
    f0 = frames;
    drive_pc(32'h0000_0005);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      pc_ = 32'h0000_0005;
    end
    chk("t3_frames", frames - f0, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);

    // 4: 1..20 on consecutive cycles -> 1..17 sent, 18 dropped
    do_reset(32'hFFFF_FFFF);
    f0 = frames;
    starts.delete();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 18) chk("t4_ovf_before", {31'd0, overflow}, 32'd0);
      if (i == 19) chk("t4_ovf_after", {31'd0, overflow}, 32'd1);
      pc_ = 32'(i);
      if (i <= 17) exp_q.push_back(32'(i));
    end
    repeat (17 * PERIOD + 20) @(negedge clk);
    chk("t4_frames", frames - f0, 32'd17);
    chk("t4_queue", exp_q.size(), 32'd0);
    chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_starts", starts.size(), 32'd17);
    for (int k = 1; k < starts.size(); k++)
      chk("t4_b2b_spacing", starts[k] - starts[k-1], PERIOD);

    // 5: reset during DATA of word 1 with 3 more queued
    do_reset(32'hFFFF_FFFF);
    f0 = frames;
    @(negedge clk); pc_ = 32'h0000_0011;
    @(negedge clk); pc_ = 32'h0000_0022;
    @(negedge clk); pc_ = 32'h0000_0033;
    @(negedge clk); pc_ = 32'h0000_0044;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_txd_async", {31'd0, txd}, 32'd1);
    chk("t5_busy_async", {31'd0, busy}, 32'd0);
    @(negedge clk);
    pc_ = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (500) @(negedge clk);
    chk("t5_no_frames", frames - f0, 32'd0);
    chk("t5_busy_idle", {31'd0, busy}, 32'd0);
    drive_pc(32'h0000_0055);
    repeat (FRAME + 10) @(negedge clk);
    chk("t5_new_frame", frames - f0, 32'd1);

    // 6: 40 distinct PCs 170 cycles apart, pointers wrap
    do_reset(32'hFFFF_FFFF);
    f0 = frames;
    for (int i = 0; i < 40; i++) begin
      v = 32'h8000_0001 + 32'(i) * 32'h0101_0203;
      drive_pc(v);
      repeat (167) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("t6_frames", frames - f0, 32'd40);
    chk("t6_overflow", {31'd0, overflow}, 32'd0);
    chk("t6_queue", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
